// File: rtl/conv_window_sequencer.sv
// Snapshots one multi-channel image and kernel set on start, then streams one zero-padded
// input window per output pixel (row-major) over valid/ready. Optional win_last port: CONV_WIN_LAST_EN.
module conv_window_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_CH      = 2,
    parameter int IMG_LEN    = 4,
    parameter int IMG_WID    = 4,
    parameter int K_LEN      = 3,
    parameter int K_WID      = 3,
    parameter int STRIDE     = 1,
    parameter int PADDING    = 0,
    localparam int OUT_LEN   = (IMG_LEN + 2*PADDING - K_LEN) / STRIDE + 1,
    localparam int OUT_WID   = (IMG_WID + 2*PADDING - K_WID) / STRIDE + 1,
    localparam int CW        = $clog2((OUT_LEN > OUT_WID) ? OUT_LEN : OUT_WID) + 1,
    localparam int IMG_BITS  = IN_CH*IMG_WID*IMG_LEN*DATA_WIDTH,
    localparam int WIN_BITS  = IN_CH*K_WID*K_LEN*DATA_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IMG_BITS-1:0] image,
    input  logic [WIN_BITS-1:0] weight,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [WIN_BITS-1:0] img_win,
    output logic [WIN_BITS-1:0] weight_win,
    output logic [CW-1:0]       out_row,
    output logic [CW-1:0]       out_col,
    output logic                busy,
`ifdef CONV_WIN_LAST_EN
    output logic                win_last,
`endif
    output logic                done
);

    if (OUT_LEN < 1 || OUT_WID < 1 || STRIDE < 1) begin : g_bad_geometry
        $error("conv_window_sequencer: kernel does not fit the padded image or STRIDE < 1");
    end

    localparam logic [CW-1:0] LAST_COL = CW'(OUT_LEN - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(OUT_WID - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t                state_q, state_d;
    logic [IMG_BITS-1:0]   img_snap_q;
    logic [WIN_BITS-1:0]   wgt_snap_q;
    logic [WIN_BITS-1:0]   img_win_q, img_win_d;
    logic [WIN_BITS-1:0]   wgt_win_q, wgt_win_d;
    logic [CW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  snap_en;
    logic                  accept;
    logic                  last_win;

    // Gathers the K_WID x K_LEN window of every channel for output pixel (r, x);
    // taps landing in the padding border read as zero.
    function automatic logic [WIN_BITS-1:0] extract(input logic [IMG_BITS-1:0] snap,
                                                    input int r, input int x);
        logic [WIN_BITS-1:0] w;
        int pr, px, src, dst;
        w = '0;
        for (int c = 0; c < IN_CH; c++) begin
            for (int j = 0; j < K_WID; j++) begin
                for (int k = 0; k < K_LEN; k++) begin
                    pr  = r*STRIDE + j;
                    px  = x*STRIDE + k;
                    dst = ((c*K_WID + j)*K_LEN + k)*DATA_WIDTH;
                    if (pr >= PADDING && pr < IMG_WID + PADDING &&
                        px >= PADDING && px < IMG_LEN + PADDING) begin
                        src = ((c*IMG_WID + pr - PADDING)*IMG_LEN + px - PADDING)*DATA_WIDTH;
                        w[dst +: DATA_WIDTH] = snap[src +: DATA_WIDTH];
                    end
                end
            end
        end
        return w;
    endfunction

    assign accept   = valid_q & win_ready;
    assign last_win = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        img_win_d = img_win_q;
        wgt_win_d = wgt_win_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        snap_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_en = 1'b1;
                    busy_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                img_win_d = extract(img_snap_q, 0, 0);
                wgt_win_d = wgt_snap_q;
                valid_d   = 1'b1;
                state_d   = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (last_win) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        img_win_d = extract(img_snap_q, int'(row_d), int'(col_d));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            img_win_q <= '0;
            wgt_win_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            img_win_q <= img_win_d;
            wgt_win_q <= wgt_win_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // NOTE: the snapshot is never read before it is loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        if (snap_en && !reset) begin
            img_snap_q <= image;
            wgt_snap_q <= weight;
        end
    end

    assign win_valid  = valid_q;
    assign img_win    = img_win_q;
    assign weight_win = wgt_win_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef CONV_WIN_LAST_EN
    assign win_last = valid_q & last_win;
`endif

endmodule
